// File: rtl/mem_bus_arbiter.sv
// Shared memory-port arbiter: fetch (i_*) and data (d_*) requesters share one
// SRAM-like port (m_*). The data side has priority while unlocked, and the grant
// is held until the address is accepted. An in-order owner FIFO routes each
// response back to whichever side issued the matching request.
module mem_bus_arbiter #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic [3:0]  outst_cnt,
    output logic        proto_err
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t          state_reg, state_next;
    logic                 owner_reg, owner_next;   // 0 = fetch, 1 = data
    logic                 sel;
    logic                 sel_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 head;
    logic [PW-1:0]        wptr_reg;
    logic [PW-1:0]        rptr_reg;
    logic [3:0]           cnt_reg;
    logic                 proto_err_reg;
    logic [MAX_OUTST-1:0] fifo_mem;

    // Requester selection and muxing of the shared port. Every output is forced
    // to zero while reset is asserted, so the port goes quiet immediately.
    always_comb begin
        sel        = (state_reg == LOCKED) ? owner_reg : d_req;
        sel_req    = sel ? d_req : i_req;
        fifo_full  = (cnt_reg >= MAX_CNT);
        fifo_empty = (cnt_reg == 4'd0);
        m_req      = rst & sel_req & ~fifo_full;
        m_wr       = m_req & (sel ? d_wr : i_wr);
        m_size     = m_req ? (sel ? d_size  : i_size)  : 2'b0;
        m_addr     = m_req ? (sel ? d_addr  : i_addr)  : 32'h0;
        m_wdata    = m_req ? (sel ? d_wdata : i_wdata) : 32'h0;
        push       = m_req & m_addr_ok;
        i_addr_ok  = push & ~sel;
        d_addr_ok  = push & sel;
        // A response with an empty FIFO is never matched against a same-cycle push.
        head       = fifo_mem[rptr_reg];
        pop        = rst & m_data_ok & ~fifo_empty;
        i_data_ok  = pop & ~head;
        d_data_ok  = pop & head;
        i_rdata    = i_data_ok ? m_rdata : 32'h0;
        d_rdata    = d_data_ok ? m_rdata : 32'h0;
        outst_cnt  = cnt_reg;
        proto_err  = proto_err_reg;
    end

    // Lock next-state: hold the grant from an unaccepted request until the
    // address is taken, or release if the owner withdraws its request.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            UNLOCKED: begin
                if (m_req && !m_addr_ok) begin
                    state_next = LOCKED;
                    owner_next = sel;
                end
            end
            LOCKED: begin
                if (push || !sel_req) begin
                    state_next = UNLOCKED;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= UNLOCKED;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    // Owner FIFO storage: one id bit per outstanding transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem <= '0;
        end else if (push) begin
            fifo_mem[wptr_reg] <= sel;
        end
    end

    // FIFO pointers and occupancy; pointers wrap at MAX_OUTST, not a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= 4'd0;
        end else begin
            if (push) begin
                wptr_reg <= (wptr_reg == LAST_PTR) ? '0 : wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= (rptr_reg == LAST_PTR) ? '0 : rptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 4'd1;
                2'b01:   cnt_reg <= cnt_reg - 4'd1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Sticky protocol error: a response arrived with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err_reg <= 1'b0;
        end else if (m_data_ok && fifo_empty) begin
            proto_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenario tasks plus a randomized run
// checked against a transaction-level model (owner queue + held grant).
module tb_mem_bus_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic [3:0]  outst_cnt;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        // one accepted fetch, then a second fetch stalled (burst in flight)
        i_req = 1; i_addr = 32'h40; m_addr_ok = 1;
        tick();
        i_addr = 32'h44; m_addr_ok = 0;
        #2 rst = 0;
        #1;
        total++;
        if ({m_req, m_addr, i_addr_ok, i_data_ok, outst_cnt} !== 39'h0) begin
            bad++;
            $display("FAIL reset_outputs: got m_req=%0b m_addr=%h cnt=%0d, want all zero",
                     m_req, m_addr, outst_cnt);
        end
        idle();
        tick();
        rst = 1;
        @(negedge clk);
        total++;
        if (proto_err !== 1'b0 || outst_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_release: got proto_err=%0b cnt=%0d, want 0 0", proto_err, outst_cnt);
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h100; m_addr_ok = 1;
        @(negedge clk);
        total++;
        if (m_addr !== 32'h100 || d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL priority_data: got m_addr=%h d_ok=%0b i_ok=%0b, want 100 1 0",
                     m_addr, d_addr_ok, i_addr_ok);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        total++;
        if (m_addr !== 32'h200 || i_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL priority_fetch: got m_addr=%h i_ok=%0b, want 200 1", m_addr, i_addr_ok);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (outst_cnt !== 4'd2) begin
            bad++;
            $display("FAIL priority_cnt: got %0d want 2", outst_cnt);
        end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        i_req = 1; i_addr = 32'h300; m_addr_ok = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                d_req = 1; d_addr = 32'h400;
            end
            @(negedge clk);
            total++;
            if (m_addr !== 32'h300 || d_addr_ok !== 1'b0 || i_addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL lock_hold c%0d: got m_addr=%h d_ok=%0b, want 300 0", c, m_addr, d_addr_ok);
            end
            tick();
        end
        m_addr_ok = 1;
        @(negedge clk);
        total++;
        if (m_addr !== 32'h300 || i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL lock_accept: got m_addr=%h i_ok=%0b, want 300 1", m_addr, i_addr_ok);
        end
        tick();
        i_req = 0;
        @(negedge clk);
        total++;
        if (m_addr !== 32'h400 || d_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL lock_release: got m_addr=%h d_ok=%0b, want 400 1", m_addr, d_addr_ok);
        end
        tick();
        idle();
    endtask

    task automatic test_ordering();
        do_reset();
        i_req = 1; i_addr = 32'h10; m_addr_ok = 1;
        tick();
        i_req = 0; d_req = 1; d_addr = 32'h20;
        tick();
        idle();
        m_data_ok = 1; m_rdata = 32'hAAAA_0001;
        @(negedge clk);
        total++;
        if (i_data_ok !== 1'b1 || i_rdata !== 32'hAAAA_0001 || d_data_ok !== 1'b0 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL order_first: got i_ok=%0b i_rd=%h d_ok=%0b d_rd=%h, want 1 aaaa0001 0 0",
                     i_data_ok, i_rdata, d_data_ok, d_rdata);
        end
        tick();
        m_rdata = 32'hBBBB_0002;
        @(negedge clk);
        total++;
        if (d_data_ok !== 1'b1 || d_rdata !== 32'hBBBB_0002 || i_data_ok !== 1'b0 || i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL order_second: got d_ok=%0b d_rd=%h i_ok=%0b i_rd=%h, want 1 bbbb0002 0 0",
                     d_data_ok, d_rdata, i_data_ok, i_rdata);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (outst_cnt !== 4'd0) begin
            bad++;
            $display("FAIL order_cnt: got %0d want 0", outst_cnt);
        end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        i_req = 1; i_addr = 32'h50; m_addr_ok = 1;
        tick();
        tick();
        d_req = 1; d_addr = 32'h60;
        @(negedge clk);
        total++;
        if (m_req !== 1'b0 || i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0 || outst_cnt !== 4'd2) begin
            bad++;
            $display("FAIL full_block: got m_req=%0b cnt=%0d, want 0 2", m_req, outst_cnt);
        end
        m_data_ok = 1;
        tick();
        // count 1: push and pop together must leave it unchanged
        @(negedge clk);
        total++;
        if (m_req !== 1'b1 || d_addr_ok !== 1'b1 || i_data_ok !== 1'b1 || outst_cnt !== 4'd1) begin
            bad++;
            $display("FAIL full_pushpop: got m_req=%0b d_ok=%0b i_dok=%0b cnt=%0d, want 1 1 1 1",
                     m_req, d_addr_ok, i_data_ok, outst_cnt);
        end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        total++;
        if (outst_cnt !== 4'd1) begin
            bad++;
            $display("FAIL full_cnt_same: got %0d want 1", outst_cnt);
        end
        tick();
        @(negedge clk);
        total++;
        if (outst_cnt !== 4'd2 || m_req !== 1'b0) begin
            bad++;
            $display("FAIL full_again: got cnt=%0d m_req=%0b want 2 0", outst_cnt, m_req);
        end
        idle();
        tick();
    endtask

    task automatic test_error();
        do_reset();
        i_req = 1; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1234;
        @(negedge clk);
        total++;
        if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0 || i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL err_nobypass: got i_dok=%0b d_dok=%0b i_rd=%h, want 0 0 0",
                     i_data_ok, d_data_ok, i_rdata);
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (proto_err !== 1'b1 || outst_cnt !== 4'd1) begin
                bad++;
                $display("FAIL err_sticky c%0d: got proto_err=%0b cnt=%0d, want 1 1", c, proto_err, outst_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int  q[$];
        int  held;
        bit  perr;
        bit  i_act, d_act;
        bit  full, e_req, e_wr, e_iok, e_dok, e_idok, e_ddok, do_pop;
        int  sel;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
        do_reset();
        held = -1; perr = 0; i_act = 0; d_act = 0;
        for (int n = 0; n < 600; n++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; i_addr = $urandom; i_wdata = $urandom;
                i_wr = 1'($urandom_range(0, 1)); i_size = 2'($urandom_range(0, 2));
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_addr = $urandom; d_wdata = $urandom;
                d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
            end
            i_req = i_act; d_req = d_act;
            m_addr_ok = ($urandom_range(0, 2) != 0);
            m_data_ok = ($urandom_range(0, 3) == 0) || (q.size() > 0 && $urandom_range(0, 1) == 0);
            m_rdata = $urandom;
            // expected behaviour from the transaction-level model
            full   = (q.size() >= MAXO);
            sel    = (held >= 0) ? held : (d_req ? 1 : 0);
            e_req  = (sel == 1 ? d_req : i_req) && !full;
            e_wr   = e_req && (sel == 1 ? d_wr : i_wr);
            e_size = e_req ? (sel == 1 ? d_size : i_size) : 2'b0;
            e_addr = e_req ? (sel == 1 ? d_addr : i_addr) : 32'h0;
            e_wdata = e_req ? (sel == 1 ? d_wdata : i_wdata) : 32'h0;
            e_iok  = e_req && m_addr_ok && sel == 0;
            e_dok  = e_req && m_addr_ok && sel == 1;
            do_pop = m_data_ok && q.size() > 0;
            e_idok = do_pop && q[0] == 0;
            e_ddok = do_pop && q[0] == 1;
            e_ird  = e_idok ? m_rdata : 32'h0;
            e_drd  = e_ddok ? m_rdata : 32'h0;
            @(negedge clk);
            total++;
            if ({m_req, m_wr, m_size, m_addr, m_wdata} !== {e_req, e_wr, e_size, e_addr, e_wdata}) begin
                bad++;
                $display("FAIL rnd_port n%0d: got req=%0b addr=%h wd=%h sz=%0d wr=%0b, want %0b %h %h %0d %0b",
                         n, m_req, m_addr, m_wdata, m_size, m_wr, e_req, e_addr, e_wdata, e_size, e_wr);
            end
            total++;
            if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== {e_iok, e_dok, e_idok, e_ddok}) begin
                bad++;
                $display("FAIL rnd_hs n%0d: got iok=%0b dok=%0b idok=%0b ddok=%0b, want %0b %0b %0b %0b",
                         n, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, e_iok, e_dok, e_idok, e_ddok);
            end
            total++;
            if (i_rdata !== e_ird || d_rdata !== e_drd) begin
                bad++;
                $display("FAIL rnd_rdata n%0d: got i=%h d=%h, want %h %h", n, i_rdata, d_rdata, e_ird, e_drd);
            end
            total++;
            if (outst_cnt !== 4'(q.size()) || proto_err !== perr) begin
                bad++;
                $display("FAIL rnd_state n%0d: got cnt=%0d err=%0b, want %0d %0b",
                         n, outst_cnt, proto_err, q.size(), perr);
            end
            // advance model with what happens at the coming edge
            if (m_data_ok && q.size() == 0) perr = 1;
            if (do_pop) void'(q.pop_front());
            if (e_req && m_addr_ok) q.push_back(sel);
            if (e_req && !m_addr_ok) held = sel;
            else if (e_req && m_addr_ok) held = -1;
            if (e_iok) i_act = 0;
            if (e_dok) d_act = 0;
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_priority();
        test_lock();
        test_ordering();
        test_full();
        test_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
